// File: rtl/reg_busy_ctrl.sv
// reg_busy_ctrl: tracks in-flight multiply/divide destination registers.
// An in-order tag FIFO records outstanding writes, a busy vector blocks
// RAW/WAW hazards at decode, and one-cycle set/reset strobes drive the
// downstream per-register SR latch array.
module reg_busy_ctrl #(
  parameter int NREG  = 32,
  parameter int TAGW  = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       issue_valid,
  input  logic [TAGW-1:0]            issue_rd,
  output logic                       issue_ready,
  input  logic                       done,
  output logic [TAGW-1:0]            done_rd,
  input  logic [TAGW-1:0]            src_a,
  input  logic [TAGW-1:0]            src_b,
  output logic                       stall,
  output logic [NREG-1:0]            busy,
  output logic [NREG-1:0]            set_vec,
  output logic [NREG-1:0]            rst_vec,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TAGW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] set_vec_reg;
  logic [NREG-1:0] rst_vec_reg;
  logic            err_reg;

  logic            fifo_full;
  logic            fifo_empty;
  logic            rd_busy;
  logic            accept;
  logic            pop;
  logic [TAGW-1:0] head;

  // Hazard, handshake and head decode; all purely combinational on registered state
  always_comb begin
    fifo_full   = (count_reg >= CW'(DEPTH));
    fifo_empty  = (count_reg == '0);
    rd_busy     = (issue_rd != '0) && busy_reg[issue_rd];
    issue_ready = !fifo_full && !rd_busy;
    accept      = issue_valid && issue_ready;
    pop         = done && !fifo_empty;
    head        = fifo_mem[rd_ptr_reg];
    done_rd     = fifo_empty ? '0 : head;
    stall       = ((src_a != '0) && busy_reg[src_a]) ||
                  ((src_b != '0) && busy_reg[src_b]) ||
                  (issue_valid && !issue_ready);
  end

  // Tag storage needs no reset: it is only observed while count is nonzero
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr_reg] <= issue_rd;
    end
  end

  // FIFO pointers, occupancy and the sticky underflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (done && fifo_empty) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Per-register busy bit and strobes; register 0 is hardwired idle
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        always_comb begin
          busy_reg[gi]    = 1'b0;
          set_vec_reg[gi] = 1'b0;
          rst_vec_reg[gi] = 1'b0;
        end
      end else begin : g_live
        logic hit_set;
        logic hit_clr;
        assign hit_set = accept && (issue_rd == TAGW'(gi));
        assign hit_clr = pop && (head == TAGW'(gi));
        // Set on issue, clear on completion; strobes last exactly one cycle
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            busy_reg[gi]    <= 1'b0;
            set_vec_reg[gi] <= 1'b0;
            rst_vec_reg[gi] <= 1'b0;
          end else begin
            set_vec_reg[gi] <= hit_set;
            rst_vec_reg[gi] <= hit_clr;
            if (hit_set) begin
              busy_reg[gi] <= 1'b1;
            end else if (hit_clr) begin
              busy_reg[gi] <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate

  assign busy    = busy_reg;
  assign set_vec = set_vec_reg;
  assign rst_vec = rst_vec_reg;
  assign count   = count_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_reg_busy_ctrl.sv
// Directed testbench for reg_busy_ctrl. Inputs change 1ns after a rising
// edge; outputs are checked 2ns after it, well clear of the next edge.
module tb_reg_busy_ctrl;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        done;
  logic [4:0]  done_rd;
  logic [4:0]  src_a;
  logic [4:0]  src_b;
  logic        stall;
  logic [31:0] busy;
  logic [31:0] set_vec;
  logic [31:0] rst_vec;
  logic [2:0]  count;
  logic        err;

  int total = 0;
  int bad   = 0;

  reg_busy_ctrl #(.NREG(32), .TAGW(5), .DEPTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .done        (done),
    .done_rd     (done_rd),
    .src_a       (src_a),
    .src_b       (src_b),
    .stall       (stall),
    .busy        (busy),
    .set_vec     (set_vec),
    .rst_vec     (rst_vec),
    .count       (count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, leave 1ns for inputs to be changed afterwards
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs before sampling
  task automatic settle();
    #1;
  endtask

  logic [4:0] exp_order [5];

  initial begin
    exp_order[0] = 5'd1; exp_order[1] = 5'd2; exp_order[2] = 5'd3;
    exp_order[3] = 5'd4; exp_order[4] = 5'd6;

    reset_n = 1'b0; issue_valid = 1'b0; issue_rd = '0; done = 1'b0;
    src_a = '0; src_b = '0;
    step(); step();
    reset_n = 1'b1;
    settle();
    $display("txn reset: busy=0x%0h count=%0d", busy, count);
    chk("rst_busy", busy, 32'h0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(issue_ready), 1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_set", set_vec, 0);
    chk("rst_rst", rst_vec, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_done_rd", 32'(done_rd), 0);

    // Issue r5, then RAW on src_a, then complete
    step();
    issue_valid = 1'b1; issue_rd = 5'd5;
    settle();
    chk("r5_ready", 32'(issue_ready), 1);
    step();
    issue_valid = 1'b0; src_a = 5'd5;
    settle();
    $display("txn issue rd=5: busy=0x%0h set=0x%0h", busy, set_vec);
    chk("r5_busy", busy, 32'h20);
    chk("r5_set", set_vec, 32'h20);
    chk("r5_stall", 32'(stall), 1);
    chk("r5_count", 32'(count), 1);
    step();
    done = 1'b1;
    settle();
    chk("r5_set_drop", set_vec, 0);
    chk("r5_done_rd", 32'(done_rd), 5);
    chk("r5_stall_hold", 32'(stall), 1);
    step();
    done = 1'b0;
    settle();
    $display("txn done rd=5: busy=0x%0h rst=0x%0h", busy, rst_vec);
    chk("r5_busy_clr", busy, 0);
    chk("r5_rst", rst_vec, 32'h20);
    chk("r5_stall_clr", 32'(stall), 0);
    chk("r5_count0", 32'(count), 0);
    src_a = '0;
    step();
    settle();
    chk("r5_rst_drop", rst_vec, 0);

    // Fill the FIFO with r1..r4
    for (int i = 1; i <= 4; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      step();
    end
    issue_rd = 5'd6; done = 1'b1;
    settle();
    $display("txn fill: count=%0d busy=0x%0h", count, busy);
    chk("full_count", 32'(count), 4);
    chk("full_busy", busy, 32'h1E);
    chk("full_set", set_vec, 32'h10);
    chk("full_ready", 32'(issue_ready), 0);
    chk("full_stall", 32'(stall), 1);
    chk("full_head", 32'(done_rd), 1);
    step();
    done = 1'b0;
    settle();
    $display("txn pop+blocked rd=6: count=%0d", count);
    chk("nobypass_count", 32'(count), 3);
    chk("nobypass_rst", rst_vec, 32'h02);
    chk("nobypass_set", set_vec, 0);
    chk("r6_ready", 32'(issue_ready), 1);
    step();
    issue_valid = 1'b0;
    settle();
    chk("r6_count", 32'(count), 4);
    chk("r6_busy", busy, 32'h5C);
    chk("r6_set", set_vec, 32'h40);
    for (int i = 1; i < 5; i++) begin
      done = 1'b1;
      settle();
      $display("txn done order[%0d]: done_rd=%0d", i, done_rd);
      chk("order", 32'(done_rd), 32'(exp_order[i]));
      step();
    end
    done = 1'b0;
    settle();
    chk("drain_count", 32'(count), 0);
    chk("drain_busy", busy, 0);
    chk("drain_rst", rst_vec, 32'h40);

    // WAW on r7, then r0 issue
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    settle();
    chk("waw_ready", 32'(issue_ready), 0);
    chk("waw_stall", 32'(stall), 1);
    step();
    done = 1'b1;
    settle();
    $display("txn waw rd=7: count=%0d ready=%0d", count, issue_ready);
    chk("waw_count", 32'(count), 1);
    chk("waw_ready_done", 32'(issue_ready), 0);
    chk("waw_done_rd", 32'(done_rd), 7);
    step();
    done = 1'b0;
    settle();
    chk("waw_freed", 32'(issue_ready), 1);
    chk("waw_count0", 32'(count), 0);
    step();
    issue_rd = 5'd0;
    settle();
    chk("r7_again_busy", busy, 32'h80);
    chk("r0_ready", 32'(issue_ready), 1);
    step();
    issue_valid = 1'b0;
    settle();
    $display("txn issue rd=0: count=%0d set=0x%0h", count, set_vec);
    chk("r0_count", 32'(count), 2);
    chk("r0_set", set_vec, 0);
    chk("r0_busy", busy, 32'h80);
    done = 1'b1;
    step();
    settle();
    chk("r0_head", 32'(done_rd), 0);
    step();
    done = 1'b0;
    settle();
    chk("r0_pop_rst", rst_vec, 0);
    chk("r0_pop_count", 32'(count), 0);
    chk("r0_err_clear", 32'(err), 0);

    // Underflow
    done = 1'b1;
    step();
    done = 1'b0;
    settle();
    $display("txn underflow: err=%0d count=%0d", err, count);
    chk("uf_err", 32'(err), 1);
    chk("uf_count", 32'(count), 0);
    step();
    settle();
    chk("uf_sticky", 32'(err), 1);

    // Async reset mid-cycle with three in flight
    for (int i = 8; i <= 10; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      step();
    end
    issue_valid = 1'b0;
    settle();
    chk("pre_rst_count", 32'(count), 3);
    reset_n = 1'b0;
    #1;
    $display("txn async reset: count=%0d busy=0x%0h", count, busy);
    chk("ar_count", 32'(count), 0);
    chk("ar_busy", busy, 0);
    chk("ar_set", set_vec, 0);
    chk("ar_err", 32'(err), 0);
    chk("ar_done_rd", 32'(done_rd), 0);
    chk("ar_ready", 32'(issue_ready), 1);
    step();
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
